synapse_matrix_scan: RTL

- Parametrised synapse crossbar memory for the neuron core: NUM_AXONS rows × NUM_NEURONS connection bits.
- Rows are loaded and read back over Wishbone.
- An on-chip scan engine walks a snapshot of the axon spike vector. For each spiking axon it streams that axon's connection row to the neuron update logic over a valid/ready handshake.

---
 rtl/synapse_matrix_scan.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/synapse_matrix_scan.sv
// Synapse crossbar memory with Wishbone row access and a spike-driven row scan engine.
// Each spiking axon in a snapshot of the spike vector streams its connection row over valid/ready.
module synapse_matrix_scan #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          NUM_AXONS   = 256,
  parameter int          NUM_NEURONS = 32,
  localparam int         AXON_W      = $clog2(NUM_AXONS)
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  input  logic [NUM_AXONS-1:0]   axon_spikes_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   conn_valid_o,
  input  logic                   conn_ready_i,
  output logic [AXON_W-1:0]      conn_axon_o,
  output logic [NUM_NEURONS-1:0] conn_o
);

  localparam int W         = NUM_NEURONS / 32;
  localparam int NUM_WORDS = NUM_AXONS * W;
  localparam int WORD_W    = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t state, state_nxt;

  logic [31:0]            mem [NUM_WORDS];
  logic [NUM_AXONS-1:0]   snapshot;
  logic [AXON_W-1:0]      index;
  logic [31:0]            word_off;
  logic [WORD_W-1:0]      wb_word;
  logic                   wb_in_range;
  logic                   wb_accept;
  logic                   advance;
  logic                   last_axon;
  logic                   start_scan;
  logic                   scan_step;
  logic                   flush_step;
  logic [NUM_NEURONS-1:0] scan_row;

  // Addresses below the base wrap to huge offsets, so the >= test must stay alongside the word bound.
  assign word_off    = (wbs_adr_i - BASE_ADDR) >> 2;
  assign wb_word     = word_off[WORD_W-1:0];
  assign wb_in_range = (wbs_adr_i >= BASE_ADDR) && (word_off < 32'(NUM_WORDS));
  assign wb_accept   = (state == IDLE) && wbs_cyc_i && wbs_stb_i && !wbs_ack_o;

  assign advance   = !conn_valid_o || conn_ready_i;
  assign last_axon = (index == AXON_W'(NUM_AXONS - 1));

  always_comb begin
    for (int s = 0; s < W; s++)
      scan_row[32*s +: 32] = mem[WORD_W'(int'(index) * W + s)];
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latches).
    state_nxt  = state;
    start_scan = 1'b0;
    scan_step  = 1'b0;
    flush_step = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          start_scan = 1'b1;
          state_nxt  = SCAN;
        end
      end
      SCAN: begin
        if (advance) begin
          scan_step = 1'b1;
          if (last_axon) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (advance) begin
          flush_step = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= wb_accept;
      wbs_dat_o <= (wb_accept && wb_in_range) ? mem[wb_word] : '0;
    end
  end

  // NOTE: the synapse array has no reset; clearing it would need a per-word mux and it is always loaded by software.
  always_ff @(posedge wb_clk_i) begin
    if (wb_accept && wb_in_range && wbs_we_i) begin
      for (int b = 0; b < 4; b++)
        if (wbs_sel_i[b]) mem[wb_word][8*b +: 8] <= wbs_dat_i[8*b +: 8];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      snapshot     <= '0;
      index        <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      conn_valid_o <= 1'b0;
      conn_axon_o  <= '0;
      conn_o       <= '0;
    end else begin
      done_o <= flush_step;
      if (start_scan) begin
        snapshot <= axon_spikes_i;
        index    <= '0;
        busy_o   <= 1'b1;
      end
      if (scan_step) begin
        if (snapshot[index]) begin
          conn_o       <= scan_row;
          conn_axon_o  <= index;
          conn_valid_o <= 1'b1;
        end else begin
          conn_valid_o <= 1'b0;
        end
        if (!last_axon) index <= index + AXON_W'(1);
      end
      if (flush_step) begin
        conn_valid_o <= 1'b0;
        busy_o       <= 1'b0;
      end
    end
  end

endmodule
